// File: rtl/quad_position_ctrl_pkg.sv
// Shared definitions for the quadrature encoder path: sequencer state encoding
// and the shortest-direction helper.
package quad_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // A modular diff below half range means count up; exactly half range also goes up.
  function automatic logic dir_up(input logic msb, input logic low_zero);
    return !msb || low_zero;
  endfunction

endpackage

// File: rtl/quad_position_ctrl_if.sv
// Command, status and encoder-side signals of the position sequencer.
interface quad_position_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 8
);
  logic             start;
  logic [CNT_W-1:0] target;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic [CNT_W-1:0] pos;
  logic             step;
  logic             dir;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] steps;

  modport master (
    output start, target, gap, abort, pos,
    input  step, dir, busy, done, err, steps
  );

  modport slave (
    input  start, target, gap, abort, pos,
    output step, dir, busy, done, err, steps
  );
endinterface

// File: rtl/quad_position_ctrl_step_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module quad_step_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/quad_position_ctrl.sv
// Closed-loop position sequencer: issues single quadrature step strobes toward a
// target count, re-evaluating the shortest direction after every step.
module quad_position_ctrl
  import quad_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GAP_W      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_STEPS  = 255
) (
  input logic                 clk,
  input logic                 reset,
  quad_position_ctrl_if.slave bus
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] MAX_Q     = CNT_W'(MAX_STEPS);
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] target_q, steps_q, diff;
  logic [GAP_W-1:0] gap_q;
  logic             dir_q, err_q;
  logic             accept, eval_go, end_err;
  logic             gap_load, gap_en, gap_zero;
  logic             set_load, set_en, set_zero;

  assign diff = target_q - bus.pos;

  quad_step_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_q - GAP_W'(1)),
    .en       (gap_en),
    .zero     (gap_zero)
  );

  quad_step_timer #(.W(SET_W)) u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (set_load),
    .load_val (SETTLE_LD),
    .en       (set_en),
    .zero     (set_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    eval_go  = 1'b0;
    end_err  = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    set_load = 1'b0;
    set_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (bus.abort) begin
          end_err  = 1'b1;
          state_nx = ST_DONE;
        end else if (diff == '0) begin
          state_nx = ST_DONE;
        end else if (steps_q == MAX_Q) begin
          end_err  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          eval_go  = 1'b1;
          gap_load = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          end_err  = 1'b1;
          state_nx = ST_DONE;
        end else if (gap_zero) begin
          state_nx = ST_STEP;
        end else begin
          gap_en = 1'b1;
        end
      end
      ST_STEP: begin
        set_load = 1'b1;
        if (bus.abort) begin
          end_err  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          end_err  = 1'b1;
          state_nx = ST_DONE;
        end else if (set_zero) begin
          state_nx = ST_EVAL;
        end else begin
          set_en = 1'b1;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The strobe in STEP always counts, even when abort arrives in that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
      gap_q    <= GAP_W'(1);
      steps_q  <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        target_q <= bus.target;
        gap_q    <= (bus.gap == '0) ? GAP_W'(1) : bus.gap;
        steps_q  <= '0;
        err_q    <= 1'b0;
      end
      if ((state == ST_STEP) && (steps_q != MAX_Q)) steps_q <= steps_q + CNT_W'(1);
      if (eval_go) dir_q <= dir_up(diff[CNT_W-1], diff[CNT_W-2:0] == '0);
      if (end_err) err_q <= 1'b1;
    end
  end

  assign bus.step  = (state == ST_STEP);
  assign bus.done  = (state == ST_DONE);
  assign bus.busy  = (state == ST_EVAL) || (state == ST_RUN) ||
                     (state == ST_STEP) || (state == ST_SETTLE);
  assign bus.dir   = dir_q;
  assign bus.err   = err_q;
  assign bus.steps = steps_q;
endmodule

// File: tb/tb_quad_position_ctrl.sv
// Closed-loop bench: a step-strobed quadrature generator and decoder feed pos back.
module tb_quad_position_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_position_ctrl_if #(.CNT_W(8), .GAP_W(8)) bus ();
  quad_position_ctrl_if #(.CNT_W(8), .GAP_W(8)) bus_to ();

  quad_position_ctrl #(.CNT_W(8), .GAP_W(8), .SETTLE_CYC(2), .MAX_STEPS(255)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  quad_position_ctrl #(.CNT_W(8), .GAP_W(8), .SETTLE_CYC(2), .MAX_STEPS(4)) dut_to (
    .clk(clk), .reset(reset), .bus(bus_to)
  );

  // Encoder generator (gray phase) and transition-counting decoder
  logic [1:0] ph = 2'd0;
  logic [1:0] ab;
  logic [1:0] ab_prev = 2'd0;
  logic [7:0] dec_cnt = 8'd0;
  logic       preset = 1'b0;
  logic [7:0] preset_val = 8'd0;

  function automatic logic [1:0] gray(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  function automatic logic [1:0] ungray(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign ab = gray(ph);

  always @(posedge clk) begin
    if (bus.step) ph <= bus.dir ? ph + 2'd1 : ph - 2'd1;
    ab_prev <= ab;
    if (preset) begin
      dec_cnt <= preset_val;
    end else if (ab != ab_prev) begin
      if (ab == gray(ungray(ab_prev) + 2'd1)) dec_cnt <= dec_cnt + 8'd1;
      else                                    dec_cnt <= dec_cnt - 8'd1;
    end
  end

  assign bus.pos    = dec_cnt;
  assign bus_to.pos = 8'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input logic [7:0] v);
    preset = 1'b1;
    preset_val = v;
    tick();
    preset = 1'b0;
    tick();
  endtask

  task automatic do_move(input logic [7:0] tgt, input logic [7:0] g, input int space, input int limit,
                         output int n_step, output int n_up, output int first, output int sp_bad,
                         output int done_at, output int n_busy);
    int t0, last;
    n_step = 0; n_up = 0; first = -1; sp_bad = 0; done_at = -1; n_busy = 0; last = 0;
    bus.start = 1'b1; bus.target = tgt; bus.gap = g;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < limit; i++) begin
      if (bus.busy) n_busy++;
      if (bus.step) begin
        n_step++;
        if (bus.dir) n_up++;
        if (first < 0) first = cyc - t0;
        else if (cyc - last != space) sp_bad++;
        last = cyc;
      end
      if (bus.done) begin
        done_at = cyc - t0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.step, bus.dir, bus.busy, bus.done, bus.err} !== 5'b0 || bus.steps !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got step/dir/busy/done/err=%b steps=%0d expected 00000 steps=0",
               {bus.step, bus.dir, bus.busy, bus.done, bus.err}, bus.steps);
    end
    n_checks++;
    if (dut.target_q !== 8'd0 || dut.gap_q !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_regs: got target_q=%0d gap_q=%0d expected 0 and 1", dut.target_q, dut.gap_q);
    end
  endtask

  task automatic test_basic();
    int ns, nu, f, sb, da, nb;
    set_pos(8'd0);
    do_move(8'd5, 8'd1, 5, 200, ns, nu, f, sb, da, nb);
    n_checks++;
    if (da < 0) begin n_fail++; $display("FAIL basic_done: no done pulse within budget"); end
    n_checks++;
    if (ns !== 5 || nu !== 5) begin
      n_fail++; $display("FAIL basic_count: got %0d steps (%0d up) expected 5 (5 up)", ns, nu);
    end
    n_checks++;
    if (f !== 2 || sb !== 0) begin
      n_fail++; $display("FAIL basic_timing: got first=%0d bad_spacing=%0d expected 2 and 0", f, sb);
    end
    n_checks++;
    if (bus.err !== 1'b0 || bus.steps !== 8'd5 || dec_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL basic_result: got err=%0d steps=%0d pos=%0d expected 0 5 5", bus.err, bus.steps, dec_cnt);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: got done=%0d busy=%0d expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_gap_zero();
    int ns, nu, f, sb, da, nb;
    set_pos(8'd0);
    do_move(8'd2, 8'd0, 5, 100, ns, nu, f, sb, da, nb);
    n_checks++;
    if (da < 0 || ns !== 2 || f !== 2 || sb !== 0) begin
      n_fail++;
      $display("FAIL gap_zero: got done_at=%0d steps=%0d first=%0d bad=%0d expected steps 2 first 2 bad 0",
               da, ns, f, sb);
    end
  endtask

  task automatic test_wrap();
    int ns, nu, f, sb, da, nb;
    set_pos(8'd250);
    do_move(8'd3, 8'd1, 5, 300, ns, nu, f, sb, da, nb);
    n_checks++;
    if (da < 0 || ns !== 9 || nu !== 9 || sb !== 0) begin
      n_fail++;
      $display("FAIL wrap_steps: got done_at=%0d steps=%0d up=%0d bad=%0d expected 9 9 0", da, ns, nu, sb);
    end
    n_checks++;
    if (dec_cnt !== 8'd3 || bus.steps !== 8'd9) begin
      n_fail++; $display("FAIL wrap_pos: got pos=%0d steps=%0d expected 3 9", dec_cnt, bus.steps);
    end
  endtask

  task automatic test_reverse();
    int ns, nu, f, sb, da, nb;
    set_pos(8'd10);
    do_move(8'd4, 8'd2, 6, 300, ns, nu, f, sb, da, nb);
    n_checks++;
    if (da < 0 || ns !== 6 || nu !== 0) begin
      n_fail++; $display("FAIL reverse_steps: got done_at=%0d steps=%0d up=%0d expected 6 0", da, ns, nu);
    end
    n_checks++;
    if (f !== 3 || sb !== 0 || dec_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL reverse_timing: got first=%0d bad=%0d pos=%0d expected 3 0 4", f, sb, dec_cnt);
    end
  endtask

  task automatic test_half_range();
    int ns, nu, f, sb, da, nb;
    set_pos(8'd0);
    do_move(8'd128, 8'd1, 5, 1000, ns, nu, f, sb, da, nb);
    n_checks++;
    if (da < 0 || ns !== 128 || nu !== 128 || dec_cnt !== 8'd128) begin
      n_fail++;
      $display("FAIL half_range: got done_at=%0d steps=%0d up=%0d pos=%0d expected 128 128 128",
               da, ns, nu, dec_cnt);
    end
  endtask

  task automatic test_no_op();
    int ns, nu, f, sb, da, nb;
    set_pos(8'd77);
    do_move(8'd77, 8'd3, 6, 20, ns, nu, f, sb, da, nb);
    n_checks++;
    if (ns !== 0 || da !== 1 || nb !== 1) begin
      n_fail++;
      $display("FAIL no_op: got steps=%0d done_at=%0d busy_cycles=%0d expected 0 1 1", ns, da, nb);
    end
    n_checks++;
    if (bus.err !== 1'b0 || bus.steps !== 8'd0) begin
      n_fail++; $display("FAIL no_op_status: got err=%0d steps=%0d expected 0 0", bus.err, bus.steps);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL no_op_pulse: got done=%0d expected 0", bus.done); end
  endtask

  task automatic test_timeout();
    int ns;
    logic seen;
    ns = 0; seen = 1'b0;
    bus_to.start = 1'b1; bus_to.target = 8'd5; bus_to.gap = 8'd1;
    tick();
    bus_to.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus_to.step) ns++;
      if (bus_to.done) begin seen = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!seen || ns !== 4) begin
      n_fail++; $display("FAIL timeout_steps: got done_seen=%0d steps=%0d expected 1 4", seen, ns);
    end
    n_checks++;
    if (bus_to.err !== 1'b1 || bus_to.steps !== 8'd4) begin
      n_fail++; $display("FAIL timeout_status: got err=%0d steps=%0d expected 1 4", bus_to.err, bus_to.steps);
    end
  endtask

  task automatic test_abort();
    int ns;
    set_pos(8'd0);
    bus.start = 1'b1; bus.target = 8'd50; bus.gap = 8'd10;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.step !== 1'b0 || bus.steps !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_done: got done=%0d err=%0d step=%0d steps=%0d expected 1 1 0 0",
               bus.done, bus.err, bus.step, bus.steps);
    end
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.step) ns++;
    end
    n_checks++;
    if (ns !== 0 || bus.err !== 1'b1 || bus.busy !== 1'b0 || dec_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_after: got steps=%0d err=%0d busy=%0d pos=%0d expected 0 1 0 0",
               ns, bus.err, bus.busy, dec_cnt);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got done=%0d busy=%0d expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid_move();
    int nd;
    logic seen;
    set_pos(8'd0);
    bus.start = 1'b1; bus.target = 8'd20; bus.gap = 8'd1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.step) begin seen = 1'b1; break; end
      tick();
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (!seen || {bus.step, bus.dir, bus.busy, bus.done, bus.err} !== 5'b0 || bus.steps !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got step_seen=%0d step/dir/busy/done/err=%b steps=%0d expected 1 00000 0",
               seen, {bus.step, bus.dir, bus.busy, bus.done, bus.err}, bus.steps);
    end
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done || bus.busy) nd++;
    end
    n_checks++;
    if (nd !== 0) begin n_fail++; $display("FAIL reset_quiet: got %0d done/busy cycles expected 0", nd); end
  endtask

  task automatic test_ignored_start();
    int ns;
    logic seen;
    set_pos(8'd0);
    bus.start = 1'b1; bus.target = 8'd3; bus.gap = 8'd1;
    tick();
    bus.target = 8'd99;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (dut.target_q !== 8'd3) begin
      n_fail++; $display("FAIL ignored_start_target: got %0d expected 3", dut.target_q);
    end
    ns = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.step) ns++;
      if (bus.done) begin seen = 1'b1; break; end
      tick();
    end
    n_checks++;
    if (!seen || ns !== 3 || bus.steps !== 8'd3 || bus.err !== 1'b0 || dec_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL ignored_start_move: got done=%0d steps=%0d/%0d err=%0d pos=%0d expected 1 3/3 0 3",
               seen, ns, bus.steps, bus.err, dec_cnt);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.target = 8'd0; bus.gap = 8'd0; bus.abort = 1'b0;
    bus_to.start = 1'b0; bus_to.target = 8'd0; bus_to.gap = 8'd0; bus_to.abort = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_basic();
    test_gap_zero();
    test_wrap();
    test_reverse();
    test_half_range();
    test_no_op();
    test_timeout();
    test_abort();
    test_reset_mid_move();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
